// File: rtl/divider_operand_fork_pkg.sv
// Shared definitions for the divider front-end and anything that talks to it.
//   fork_state_t   : front-end FSM state encoding
//   DIV_W          : default operand width
//   DIV_CNT_W      : default width of the issued-pair counter
//   REQ_*          : field positions of {lhs, rhs} inside a combined request
package divider_operand_fork_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FORK = 2'd1,
        ERR  = 2'd2
    } fork_state_t;

    localparam int DIV_W     = 4;
    localparam int DIV_CNT_W = 8;

    localparam int REQ_LHS_MSB = 2 * DIV_W - 1;
    localparam int REQ_LHS_LSB = DIV_W;
    localparam int REQ_RHS_MSB = DIV_W - 1;
    localparam int REQ_RHS_LSB = 0;

endpackage

// File: rtl/divider_operand_fork.sv
// Front-end for the iterative divider. Registers one {lhs, rhs} request and
// forks it onto the divider's independent lhs/rhs ready-valid channels. A
// request whose divisor is zero is diverted to the error channel instead.
// Ports:
//   clk, rst                      clock, async active-low reset
//   issue__req/_vld/_rdy          combined request in ([2W-1:W]=lhs, [W-1:0]=rhs)
//   divider__lhs/_vld/_rdy        dividend out
//   divider__rhs/_vld/_rdy        divisor out
//   issue__err/_vld/_rdy          lhs of a zero-divisor request
//   issued_count                  pairs fully delivered (wraps)
//   zero_count                    rejected requests (saturates)
module divider_operand_fork
    import divider_operand_fork_pkg::*;
#(
    parameter int W  = DIV_W,
    parameter int CW = DIV_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2*W-1:0] issue__req,
    input  logic          issue__req_vld,
    output logic          issue__req_rdy,
    output logic [W-1:0]  divider__lhs,
    output logic          divider__lhs_vld,
    input  logic          divider__lhs_rdy,
    output logic [W-1:0]  divider__rhs,
    output logic          divider__rhs_vld,
    input  logic          divider__rhs_rdy,
    output logic [W-1:0]  issue__err,
    output logic          issue__err_vld,
    input  logic          issue__err_rdy,
    output logic [CW-1:0] issued_count,
    output logic [W-1:0]  zero_count
);

    fork_state_t   state_q, state_d;
    logic [W-1:0]  hold_lhs_q, hold_lhs_d;
    logic [W-1:0]  hold_rhs_q, hold_rhs_d;
    logic          lhs_sent_q, lhs_sent_d;
    logic          rhs_sent_q, rhs_sent_d;
    logic          lhs_vld_q, lhs_vld_d;
    logic          rhs_vld_q, rhs_vld_d;
    logic          err_vld_q, err_vld_d;
    logic [CW-1:0] issued_count_q, issued_count_d;
    logic [W-1:0]  zero_count_q, zero_count_d;

    logic lhs_hs, rhs_hs;

    // Handshakes are taken against the registered valids, so no input ready
    // reaches an output combinationally.
    assign lhs_hs = lhs_vld_q & divider__lhs_rdy;
    assign rhs_hs = rhs_vld_q & divider__rhs_rdy;

    always_comb begin
        state_d        = state_q;
        hold_lhs_d     = hold_lhs_q;
        hold_rhs_d     = hold_rhs_q;
        lhs_sent_d     = lhs_sent_q;
        rhs_sent_d     = rhs_sent_q;
        issued_count_d = issued_count_q;
        zero_count_d   = zero_count_q;

        case (state_q)
            IDLE: begin
                if (issue__req_vld) begin
                    hold_lhs_d = issue__req[2*W-1:W];
                    hold_rhs_d = issue__req[W-1:0];
                    lhs_sent_d = 1'b0;
                    rhs_sent_d = 1'b0;
                    state_d    = (issue__req[W-1:0] != '0) ? FORK : ERR;
                end
            end
            FORK: begin
                // Each branch is send-once: the sent flag latches on its own
                // handshake and the pair retires when both flags are set.
                lhs_sent_d = lhs_sent_q | lhs_hs;
                rhs_sent_d = rhs_sent_q | rhs_hs;
                if (lhs_sent_d && rhs_sent_d) begin
                    state_d        = IDLE;
                    issued_count_d = issued_count_q + 1'b1;
                end
            end
            ERR: begin
                if (issue__err_rdy) begin
                    state_d = IDLE;
                    if (zero_count_q != '1) zero_count_d = zero_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Valids are registered copies of what the next state will present.
        lhs_vld_d = (state_d == FORK) && !lhs_sent_d;
        rhs_vld_d = (state_d == FORK) && !rhs_sent_d;
        err_vld_d = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            hold_lhs_q     <= '0;
            hold_rhs_q     <= '0;
            lhs_sent_q     <= 1'b0;
            rhs_sent_q     <= 1'b0;
            lhs_vld_q      <= 1'b0;
            rhs_vld_q      <= 1'b0;
            err_vld_q      <= 1'b0;
            issued_count_q <= '0;
            zero_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            hold_lhs_q     <= hold_lhs_d;
            hold_rhs_q     <= hold_rhs_d;
            lhs_sent_q     <= lhs_sent_d;
            rhs_sent_q     <= rhs_sent_d;
            lhs_vld_q      <= lhs_vld_d;
            rhs_vld_q      <= rhs_vld_d;
            err_vld_q      <= err_vld_d;
            issued_count_q <= issued_count_d;
            zero_count_q   <= zero_count_d;
        end
    end

    // Ready is gated by reset itself so it reads 0 for the whole time reset
    // is held, even though the state register already sits in IDLE.
    assign issue__req_rdy   = (state_q == IDLE) && rst;
    assign divider__lhs     = hold_lhs_q;
    assign divider__rhs     = hold_rhs_q;
    assign divider__lhs_vld = lhs_vld_q;
    assign divider__rhs_vld = rhs_vld_q;
    assign issue__err       = hold_lhs_q;
    assign issue__err_vld   = err_vld_q;
    assign issued_count     = issued_count_q;
    assign zero_count       = zero_count_q;

endmodule

// File: tb/tb_divider_operand_fork.sv
module tb_divider_operand_fork;
    import divider_operand_fork_pkg::*;

    localparam int W  = DIV_W;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2*W-1:0] issue__req = '0;
    logic          issue__req_vld = 1'b0;
    logic          issue__req_rdy;
    logic [W-1:0]  divider__lhs;
    logic          divider__lhs_vld;
    logic          divider__lhs_rdy = 1'b0;
    logic [W-1:0]  divider__rhs;
    logic          divider__rhs_vld;
    logic          divider__rhs_rdy = 1'b0;
    logic [W-1:0]  issue__err;
    logic          issue__err_vld;
    logic          issue__err_rdy = 1'b0;
    logic [CW-1:0] issued_count;
    logic [W-1:0]  zero_count;

    divider_operand_fork #(.W(W), .CW(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .issue__req       (issue__req),
        .issue__req_vld   (issue__req_vld),
        .issue__req_rdy   (issue__req_rdy),
        .divider__lhs     (divider__lhs),
        .divider__lhs_vld (divider__lhs_vld),
        .divider__lhs_rdy (divider__lhs_rdy),
        .divider__rhs     (divider__rhs),
        .divider__rhs_vld (divider__rhs_vld),
        .divider__rhs_rdy (divider__rhs_rdy),
        .issue__err       (issue__err),
        .issue__err_vld   (issue__err_vld),
        .issue__err_rdy   (issue__err_rdy),
        .issued_count     (issued_count),
        .zero_count       (zero_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    // Reference counters, derived from the request history.
    int m_issued = 0;
    int m_zero   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request until accepted (bounded), then drop valid.
    task automatic put_req(input logic [W-1:0] l, input logic [W-1:0] r);
        int n = 0;
        while (!issue__req_rdy && n < 50) begin tick(); n++; end
        n_cmp++;
        if (!issue__req_rdy) begin
            n_err++;
            $display("FAIL put_req_timeout: req_rdy=%0b required 1", issue__req_rdy);
        end
        issue__req     = {l, r};
        issue__req_vld = 1'b1;
        tick();
        issue__req_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({issue__req_rdy, divider__lhs_vld, divider__rhs_vld, issue__err_vld} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: rdy/lv/rv/ev=%b required 0000",
                     {issue__req_rdy, divider__lhs_vld, divider__rhs_vld, issue__err_vld});
        end
        n_cmp++;
        if ({divider__lhs, divider__rhs, issue__err, issued_count, zero_count} !== '0) begin
            n_err++;
            $display("FAIL reset_data: lhs=%0d rhs=%0d err=%0d ic=%0d zc=%0d required all 0",
                     divider__lhs, divider__rhs, issue__err, issued_count, zero_count);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (issue__req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_rdy: req_rdy=%0b required 1", issue__req_rdy);
        end
    endtask

    task automatic test_basic();
        divider__lhs_rdy = 1'b1;
        divider__rhs_rdy = 1'b1;
        put_req(4'd8, 4'd2);
        n_cmp++;
        if (!(divider__lhs_vld === 1'b1 && divider__rhs_vld === 1'b1 &&
              divider__lhs === 4'd8 && divider__rhs === 4'd2 && issue__req_rdy === 1'b0)) begin
            n_err++;
            $display("FAIL basic_fork: lv=%0b rv=%0b lhs=%0d rhs=%0d rdy=%0b required 1 1 8 2 0",
                     divider__lhs_vld, divider__rhs_vld, divider__lhs, divider__rhs, issue__req_rdy);
        end
        tick();
        m_issued = (m_issued + 1) % 16;
        n_cmp++;
        if (!(issued_count === CW'(m_issued) && issue__req_rdy === 1'b1 &&
              divider__lhs_vld === 1'b0 && divider__rhs_vld === 1'b0)) begin
            n_err++;
            $display("FAIL basic_done: ic=%0d rdy=%0b lv=%0b rv=%0b required %0d 1 0 0",
                     issued_count, issue__req_rdy, divider__lhs_vld, divider__rhs_vld, m_issued);
        end
    endtask

    task automatic test_split();
        int lc = 0, rc = 0;
        divider__lhs_rdy = 1'b0;
        divider__rhs_rdy = 1'b1;
        put_req(4'd8, 4'd2);
        for (int c = 0; c < 7; c++) begin
            if (c == 3) divider__lhs_rdy = 1'b1;
            if (divider__lhs_vld) begin
                lc++;
                n_cmp++;
                if (divider__lhs !== 4'd8 || issued_count !== CW'(m_issued)) begin
                    n_err++;
                    $display("FAIL split_hold: lhs=%0d ic=%0d required 8 %0d",
                             divider__lhs, issued_count, m_issued);
                end
            end
            if (divider__rhs_vld) rc++;
            tick();
        end
        m_issued = (m_issued + 1) % 16;
        n_cmp++;
        if (lc != 4 || rc != 1 || issued_count !== CW'(m_issued)) begin
            n_err++;
            $display("FAIL split_counts: lhs_cycles=%0d rhs_cycles=%0d ic=%0d required 4 1 %0d",
                     lc, rc, issued_count, m_issued);
        end
    endtask

    task automatic test_zero();
        int ec = 0, dv = 0;
        issue__err_rdy = 1'b0;
        put_req(4'd5, 4'd0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) issue__err_rdy = 1'b1;
            if (issue__err_vld) begin
                ec++;
                n_cmp++;
                if (issue__err !== 4'd5) begin
                    n_err++;
                    $display("FAIL zero_data: err=%0d required 5", issue__err);
                end
            end
            if (divider__lhs_vld || divider__rhs_vld) dv++;
            tick();
        end
        m_zero = (m_zero < 15) ? m_zero + 1 : 15;
        n_cmp++;
        if (ec != 3 || dv != 0 || zero_count !== W'(m_zero) || issued_count !== CW'(m_issued)) begin
            n_err++;
            $display("FAIL zero_counts: err_cycles=%0d div_vld_cycles=%0d zc=%0d ic=%0d required 3 0 %0d %0d",
                     ec, dv, zero_count, issued_count, m_zero, m_issued);
        end
    endtask

    task automatic test_counters();
        divider__lhs_rdy = 1'b1;
        divider__rhs_rdy = 1'b1;
        issue__err_rdy   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            put_req(W'($urandom), W'($urandom_range(1, 15)));
            tick();
        end
        m_issued = (m_issued + 17) % 16;
        n_cmp++;
        if (issued_count !== CW'(m_issued)) begin
            n_err++;
            $display("FAIL issued_wrap: ic=%0d required %0d", issued_count, m_issued);
        end
        for (int i = 0; i < 16; i++) begin
            put_req(W'($urandom), 4'd0);
            tick();
        end
        m_zero = (m_zero + 16 > 15) ? 15 : m_zero + 16;
        n_cmp++;
        if (zero_count !== W'(m_zero)) begin
            n_err++;
            $display("FAIL zero_saturate: zc=%0d required %0d", zero_count, m_zero);
        end
    endtask

    task automatic test_reset_mid_fork();
        int rc = 0;
        divider__lhs_rdy = 1'b1;
        divider__rhs_rdy = 1'b0;
        put_req(4'd6, 4'd7);
        tick(); // lhs handshakes, rhs stalls
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({divider__lhs_vld, divider__rhs_vld, issue__err_vld, issue__req_rdy} !== 4'b0 ||
            issued_count !== '0 || zero_count !== '0) begin
            n_err++;
            $display("FAIL midreset_clear: lv/rv/ev/rdy=%b ic=%0d zc=%0d required 0000 0 0",
                     {divider__lhs_vld, divider__rhs_vld, issue__err_vld, issue__req_rdy},
                     issued_count, zero_count);
        end
        m_issued = 0;
        m_zero   = 0;
        tick();
        rst = 1'b1;
        divider__rhs_rdy = 1'b1;
        tick();
        put_req(4'd9, 4'd3);
        n_cmp++;
        if (!(divider__lhs_vld === 1'b1 && divider__rhs_vld === 1'b1 &&
              divider__lhs === 4'd9 && divider__rhs === 4'd3)) begin
            n_err++;
            $display("FAIL midreset_refork: lv=%0b rv=%0b lhs=%0d rhs=%0d required 1 1 9 3",
                     divider__lhs_vld, divider__rhs_vld, divider__lhs, divider__rhs);
        end
        for (int c = 0; c < 4; c++) begin
            if (divider__rhs_vld) rc++;
            tick();
        end
        m_issued = 1;
        n_cmp++;
        if (rc != 1 || issued_count !== CW'(m_issued)) begin
            n_err++;
            $display("FAIL midreset_done: rhs_cycles=%0d ic=%0d required 1 %0d",
                     rc, issued_count, m_issued);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rq_l[10];
        logic [W-1:0] rq_r[10];
        logic [W-1:0] exp_l[$], exp_r[$], exp_e[$];
        logic [W-1:0] got_l[$], got_r[$], got_e[$];
        int sent = 0;
        bit done = 0;
        bit acc;
        logic p_lv = 0, p_lr = 0, p_rv = 0, p_rr = 0, p_ev = 0, p_er = 0;
        logic [W-1:0] p_l = '0, p_r = '0, p_e = '0;
        for (int i = 0; i < 10; i++) begin
            rq_l[i] = W'($urandom);
            rq_r[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 15));
            if (rq_r[i] != 0) begin
                exp_l.push_back(rq_l[i]);
                exp_r.push_back(rq_r[i]);
                m_issued = (m_issued + 1) % 16;
            end else begin
                exp_e.push_back(rq_l[i]);
                m_zero = (m_zero < 15) ? m_zero + 1 : 15;
            end
        end
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            divider__lhs_rdy = 1'($urandom_range(0, 1));
            divider__rhs_rdy = 1'($urandom_range(0, 1));
            issue__err_rdy   = 1'($urandom_range(0, 1));
            if ((p_lv && !p_lr && !(divider__lhs_vld === 1'b1 && divider__lhs === p_l)) ||
                (p_rv && !p_rr && !(divider__rhs_vld === 1'b1 && divider__rhs === p_r)) ||
                (p_ev && !p_er && !(issue__err_vld === 1'b1 && issue__err === p_e))) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b_stable: cycle %0d lv=%0b lhs=%0d rv=%0b rhs=%0d ev=%0b err=%0d required held %0d %0d %0d",
                         cyc, divider__lhs_vld, divider__lhs, divider__rhs_vld, divider__rhs,
                         issue__err_vld, issue__err, p_l, p_r, p_e);
            end
            if (divider__lhs_vld && divider__lhs_rdy) got_l.push_back(divider__lhs);
            if (divider__rhs_vld && divider__rhs_rdy) got_r.push_back(divider__rhs);
            if (issue__err_vld && issue__err_rdy)     got_e.push_back(issue__err);
            issue__req_vld = (sent < 10) && issue__req_rdy;
            if (sent < 10) issue__req = {rq_l[sent], rq_r[sent]};
            acc = issue__req_vld && issue__req_rdy;
            p_lv = divider__lhs_vld; p_lr = divider__lhs_rdy; p_l = divider__lhs;
            p_rv = divider__rhs_vld; p_rr = divider__rhs_rdy; p_r = divider__rhs;
            p_ev = issue__err_vld;   p_er = issue__err_rdy;   p_e = issue__err;
            tick();
            if (acc) sent++;
            if (sent == 10 && issue__req_rdy) done = 1;
        end
        issue__req_vld = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL b2b_timeout: sent=%0d required 10 and drained", sent);
        end
        n_cmp++;
        if (got_l.size() != exp_l.size() || got_r.size() != exp_r.size() || got_e.size() != exp_e.size()) begin
            n_err++;
            $display("FAIL b2b_sizes: lhs=%0d rhs=%0d err=%0d required %0d %0d %0d",
                     got_l.size(), got_r.size(), got_e.size(), exp_l.size(), exp_r.size(), exp_e.size());
        end
        for (int i = 0; i < exp_l.size() && i < got_l.size() && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_err++;
                $display("FAIL b2b_order[%0d]: lhs=%0d rhs=%0d required %0d %0d",
                         i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
            end
        end
        for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
            n_cmp++;
            if (got_e[i] !== exp_e[i]) begin
                n_err++;
                $display("FAIL b2b_err[%0d]: err=%0d required %0d", i, got_e[i], exp_e[i]);
            end
        end
        n_cmp++;
        if (issued_count !== CW'(m_issued) || zero_count !== W'(m_zero)) begin
            n_err++;
            $display("FAIL b2b_counts: ic=%0d zc=%0d required %0d %0d",
                     issued_count, zero_count, m_issued, m_zero);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_split();
        test_zero();
        test_counters();
        test_reset_mid_fork();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/divider_operand_fork.md
# divider_operand_fork

Upstream front-end for the iterative divider. It accepts one combined `{lhs, rhs}` request per handshake and registers it. It then forks the operands onto the divider's two independent ready/valid operand channels. Requests with a zero divisor never reach the divider; they go to a separate error channel. Per-outcome counters are exposed for debug and bench scoreboarding.

## Interface
Parameters:
- `W`, 4: operand width; matches the divider's operand width.
- `CW`, 8: width of `issued_count`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `issue__req`  in  2W  request; `[2W-1:W]` = lhs, `[W-1:0]` = rhs.
- `issue__req_vld`  in  1  request valid.
- `issue__req_rdy`  out  1  request ready.
- `divider__lhs`  out  W  dividend to the divider.
- `divider__lhs_vld`  out  1
- `divider__lhs_rdy`  in  1
- `divider__rhs`  out  W  divisor to the divider.
- `divider__rhs_vld`  out  1
- `divider__rhs_rdy`  in  1
- `issue__err`  out  W  lhs of a request rejected for rhs == 0.
- `issue__err_vld`  out  1
- `issue__err_rdy`  in  1
- `issued_count`  out  CW  pairs fully delivered to the divider; wraps.
- `zero_count`  out  W  rejected requests; saturates at all-ones.

## Operation
- One-entry holding register `hold_lhs`, `hold_rhs`; FSM states: IDLE, FORK, ERR.
- **IDLE**
  - `issue__req_rdy` = 1; all other valids are 0.
  - On `req_vld`, capture the request and clear `lhs_sent`/`rhs_sent`.
  - If rhs != 0, go to FORK; otherwise go to ERR.
- **FORK**
  - `divider__lhs_vld` = !lhs_sent; `divider__rhs_vld` = !rhs_sent.
  - Data outputs drive the held operands.
  - A handshake on a branch sets that branch's sent flag; its valid drops the next cycle and never re-asserts for the same pair.
  - When both branches are done (including both handshaking in the same cycle), go to IDLE and increment `issued_count`.
- **ERR**
  - `issue__err_vld` = 1, `issue__err` = hold_lhs.
  - On `err_rdy`, go to IDLE and increment `zero_count` unless it is already all-ones.
- `issue__req_rdy` = 0 in FORK and ERR. There is no same-cycle pass-through, so peak throughput is one request per 2 cycles.
- Valids are never withdrawn and data never changes while a valid is high and unacknowledged.
- Arithmetic:
  - `issued_count` is modulo 2^CW.
  - `zero_count` is saturating.
  - No width extension on data paths.
- Reset (asserted asynchronously): state IDLE, flags 0, holding register 0, all `*_vld` = 0, all data outputs = 0, both counters 0.
  - An in-flight pair or error is discarded; a half-forked pair is not completed.
  - `issue__req_rdy` reads 0 while `rst` is low.
  - It reads 1 from the first cycle after release.

## Timing
- Request accepted at edge k: divider valids (or err valid) are high during cycle k+1.
- Both divider readies held high: the pair completes at edge k+1, and `issued_count` shows +1 in cycle k+2.
- The next request can be accepted at edge k+2.
- All outputs are registered, except `issue__req_rdy`, which decodes the state register. No combinational path from any input `*_rdy` to any output.
- Reset release is synchronous to `clk` in the integration; the block relies on this.

## Structure
- Shared divider package holds:
  - the FSM state enum `fork_state_t` (IDLE/FORK/ERR);
  - the default widths `DIV_W = 4` and `DIV_CNT_W = 8`;
  - the request field positions (`REQ_LHS_MSB` etc.), so that the divider wrapper and bench agree.
- Single module, no sub-modules.
  - The two branches are identical send-once channel slots, but they stay inline.
  - Do not factor them into a sub-module: each is about 10 lines.

## Test plan
- **Basic pair.** Req = {8, 2}, all readies 1.
  - Cycle k+1: lhs = 8, rhs = 2, both vld.
  - `issued_count` goes 0→1.
  - `req_rdy` returns at k+2.
- **Split backpressure.** `rhs_rdy` = 1, `lhs_rdy` = 0 for 3 cycles, then 1.
  - `rhs_vld` is high exactly 1 cycle.
  - `lhs_vld` is held 4 cycles with lhs = 8 stable.
  - The count increments only after the lhs handshake.
- **Zero divisor.** Req = {5, 0} with `err_rdy` low for 2 cycles.
  - `err_vld` is high 3 cycles with err = 5.
  - Divider valids stay 0; `zero_count` = 1; `issued_count` unchanged.
- **Counter edges.**
  - With CW = 4, issue 17 valid pairs: `issued_count` reads 1 (wrapped).
  - With W = 4, issue 16 zero-divisor requests: `zero_count` stays 15.
- **Reset mid-FORK.** After lhs has handshaken and `rhs_rdy` = 0, pull `rst` low between edges.
  - All valids drop to 0 immediately; counters are 0.
  - After release, req = {9, 3} forks cleanly; the old rhs is never re-sent.
- **Back-to-back stream.** 10 random pairs with random readies.
  - The scoreboard sees lhs/rhs orders identical to the request order.
  - No duplicated or dropped operands.
